// File: rtl/phy_rx_deframer.sv
// phy_rx_deframer
//   Receive-side deframer for the 1-bit serial stream produced by the TX
//   serializer. Hunts for the idle/comma symbol to find byte alignment.
//   It declares the link active after BC_LOCK consecutive aligned idle bytes.
//   It then de-interleaves bytes round-robin into four 8-bit lanes.
//
// Ports
//   clk_32f      in   bit clock, all logic on its rising edge
//   reset        in   synchronous active-low reset
//   data_in      in   serial stream, MSB of each byte first
//   active       out  high while aligned and locked
//   byte_out     out  last assembled byte
//   byte_valid   out  one-cycle pulse per assembled byte
//   data_out0..3 out  lane registers (lane 0 first in TX mux order)
//   valid_out0..3 out lane valid: last slot of that lane carried a non-idle byte
//   frame_done   out  one-cycle pulse when the lane 3 slot is written
module phy_rx_deframer #(
    parameter logic [7:0]  BC_SYMBOL = 8'hBC,
    parameter int unsigned BC_LOCK   = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic       active,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic [7:0] data_out0,
    output logic [7:0] data_out1,
    output logic [7:0] data_out2,
    output logic [7:0] data_out3,
    output logic       valid_out0,
    output logic       valid_out1,
    output logic       valid_out2,
    output logic       valid_out3,
    output logic       frame_done
);

    localparam logic [3:0] LOCK_CNT = 4'(BC_LOCK);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_SYNC,
        ST_ACTIVE
    } state_e;

    state_e      state_q, state_d;
    // Only the previous 7 bits are stored; the 8th bit of a candidate byte
    // is always the live data_in bit.
    logic [6:0]  sr_q, sr_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  bc_cnt_q, bc_cnt_d;
    logic [1:0]  lane_cnt_q, lane_cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic        byte_valid_q, byte_valid_d;
    logic [7:0]  lane_data_q [4];
    logic [7:0]  lane_data_d [4];
    logic [3:0]  lane_vld_q, lane_vld_d;
    logic        frame_done_q, frame_done_d;

    logic [7:0]  cand;
    logic        boundary;
    logic        cand_is_bc;

    assign cand       = {sr_q, data_in};
    assign boundary   = (bit_cnt_q == 3'd7);
    assign cand_is_bc = (cand == BC_SYMBOL);

    always_comb begin
        state_d      = state_q;
        sr_d         = cand[6:0];
        bit_cnt_d    = bit_cnt_q + 3'd1;
        bc_cnt_d     = bc_cnt_q;
        lane_cnt_d   = lane_cnt_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        lane_data_d  = lane_data_q;
        lane_vld_d   = lane_vld_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_HUNT: begin
                // Bit phase is undefined until a match; the cycle after a
                // match is bit 0 of the next aligned byte.
                bit_cnt_d = '0;
                if (cand_is_bc) begin
                    bc_cnt_d = 4'd1;
                    if (LOCK_CNT == 4'd1) begin
                        state_d    = ST_ACTIVE;
                        lane_cnt_d = '0;
                    end else begin
                        state_d = ST_SYNC;
                    end
                end
            end

            ST_SYNC: begin
                if (boundary) begin
                    if (cand_is_bc) begin
                        if (bc_cnt_q + 4'd1 == LOCK_CNT) begin
                            state_d    = ST_ACTIVE;
                            lane_cnt_d = '0;
                        end
                        bc_cnt_d = bc_cnt_q + 4'd1;
                    end else begin
                        state_d  = ST_HUNT;
                        bc_cnt_d = '0;
                    end
                end
            end

            ST_ACTIVE: begin
                if (boundary) begin
                    byte_d                  = cand;
                    byte_valid_d            = 1'b1;
                    lane_data_d[lane_cnt_q] = cand;
                    lane_vld_d[lane_cnt_q]  = !cand_is_bc;
                    lane_cnt_d              = lane_cnt_q + 2'd1;
                    frame_done_d            = (lane_cnt_q == 2'd3);
                end
            end

            default: state_d = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            state_q      <= ST_HUNT;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            bc_cnt_q     <= '0;
            lane_cnt_q   <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            lane_data_q  <= '{default: '0};
            lane_vld_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            bc_cnt_q     <= bc_cnt_d;
            lane_cnt_q   <= lane_cnt_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            lane_data_q  <= lane_data_d;
            lane_vld_q   <= lane_vld_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign active     = (state_q == ST_ACTIVE);
    assign byte_out   = byte_q;
    assign byte_valid = byte_valid_q;
    assign data_out0  = lane_data_q[0];
    assign data_out1  = lane_data_q[1];
    assign data_out2  = lane_data_q[2];
    assign data_out3  = lane_data_q[3];
    assign valid_out0 = lane_vld_q[0];
    assign valid_out1 = lane_vld_q[1];
    assign valid_out2 = lane_vld_q[2];
    assign valid_out3 = lane_vld_q[3];
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_phy_rx_deframer.sv
// tb_phy_rx_deframer
//   Scoreboard bench for phy_rx_deframer. Stimulus tasks push the expected
//   byte/lane/frame state for every byte sent while the link is active; a
//   monitor pops one entry per byte_valid pulse and compares.
module tb_phy_rx_deframer;

    localparam logic [7:0]  BC      = 8'hBC;
    localparam int unsigned LOCK_N  = 4;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b0;
    logic       data_in = 1'b0;
    logic       active;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic [7:0] data_out0, data_out1, data_out2, data_out3;
    logic       valid_out0, valid_out1, valid_out2, valid_out3;
    logic       frame_done;

    phy_rx_deframer #(
        .BC_SYMBOL (BC),
        .BC_LOCK   (LOCK_N)
    ) dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .data_in    (data_in),
        .active     (active),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .data_out0  (data_out0),
        .data_out1  (data_out1),
        .data_out2  (data_out2),
        .data_out3  (data_out3),
        .valid_out0 (valid_out0),
        .valid_out1 (valid_out1),
        .valid_out2 (valid_out2),
        .valid_out3 (valid_out3),
        .frame_done (frame_done)
    );

    always #5 clk_32f = ~clk_32f;

    typedef struct packed {
        logic [7:0]  b;
        logic [31:0] lanes;
        logic [3:0]  vld;
        logic        fd;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    // Reference model: link status, the four lane contents and the next slot.
    bit          mdl_active = 1'b0;
    logic [31:0] mdl_lanes  = '0;
    logic [3:0]  mdl_vld    = '0;
    int          mdl_slot   = 0;

    wire [31:0] dut_lanes = {data_out3, data_out2, data_out1, data_out0};
    wire [3:0]  dut_vld   = {valid_out3, valid_out2, valid_out1, valid_out0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        exp_t e;
        if (mdl_active) begin
            mdl_lanes[mdl_slot*8 +: 8] = b;
            mdl_vld[mdl_slot]          = (b != BC);
            e.b     = b;
            e.lanes = mdl_lanes;
            e.vld   = mdl_vld;
            e.fd    = (mdl_slot == 3);
            exp_q.push_back(e);
            mdl_slot = (mdl_slot + 1) % 4;
        end
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_active"}, 32'(active), 0);
        chk({tag, "_byte_out"}, 32'(byte_out), 0);
        chk({tag, "_byte_valid"}, 32'(byte_valid), 0);
        chk({tag, "_lanes"}, dut_lanes, 0);
        chk({tag, "_valids"}, 32'(dut_vld), 0);
        chk({tag, "_frame_done"}, 32'(frame_done), 0);
    endtask

    task automatic do_reset(input int cycles);
        reset      = 1'b0;
        mdl_active = 1'b0;
        mdl_lanes  = '0;
        mdl_vld    = '0;
        mdl_slot   = 0;
        for (int c = 0; c < cycles; c++) begin
            data_in = 1'($urandom);
            @(posedge clk_32f);
            #1;
            check_all_zero("reset");
        end
        reset = 1'b1;
    endtask

    // From HUNT: nbits random bits, then LOCK_N idle bytes; active must rise
    // exactly one edge after the last bit of the final idle byte.
    task automatic lock_link(input int nbits);
        logic [7:0] bc_v;
        bc_v = BC;
        for (int i = 0; i < nbits; i++) send_bit(1'($urandom));
        for (int k = 0; k < int'(LOCK_N) - 1; k++) begin
            send_byte(BC);
            chk("active_early", 32'(active), 0);
        end
        for (int i = 7; i >= 1; i--) send_bit(bc_v[i]);
        chk("active_before_last_bit", 32'(active), 0);
        send_bit(bc_v[0]);
        chk("active_after_lock", 32'(active), 1);
        mdl_active = 1'b1;
        mdl_slot   = 0;
    endtask

    task automatic send_random_bytes(input int n);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(3) == 0) send_byte(BC);
            else send_byte(8'($urandom));
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        logic prev_bv;
        prev_bv = 1'b0;
        forever begin
            @(negedge clk_32f);
            if (byte_valid) begin
                chk("byte_valid_single_cycle", 32'(prev_bv), 0);
                chk("byte_valid_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("byte_out", 32'(byte_out), 32'(e.b));
                    chk("lanes", dut_lanes, e.lanes);
                    chk("lane_valids", 32'(dut_vld), 32'(e.vld));
                    chk("frame_done", 32'(frame_done), 32'(e.fd));
                end
            end else begin
                chk("frame_done_without_byte", 32'(frame_done), 0);
            end
            prev_bv = byte_valid;
        end
    end

    initial begin
        // Reset hold with random data.
        do_reset(3);

        // Broken lock from an offset: three idles then a data byte restarts the hunt.
        for (int i = 0; i < 3; i++) send_bit(1'($urandom));
        for (int k = 0; k < 3; k++) begin
            send_byte(BC);
            chk("broken_active_bc", 32'(active), 0);
        end
        send_byte(8'h5A);
        chk("broken_active_5a", 32'(active), 0);
        lock_link(0);

        // First frame.
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);

        // Idle slot in lane 1.
        send_byte(8'hA1); send_byte(BC); send_byte(8'hA3); send_byte(8'hA4);

        // Lane wrap over two frames.
        for (int k = 1; k <= 8; k++) send_byte(8'(k));
        #4;
        chk("wrap_lanes", dut_lanes, 32'h08070605);
        chk("wrap_valids", 32'(dut_vld), 32'hF);

        send_random_bytes(24);

        // Reset in the middle of a data byte: 4 bits sent, then reset.
        for (int i = 0; i < 4; i++) send_bit(1'($urandom));
        do_reset(1);
        chk("queue_empty_after_reset", 32'(exp_q.size()), 0);

        // Relock with a random offset; a full idle run is required again.
        lock_link(int'($urandom_range(7)));
        send_random_bytes(24);

        repeat (2) @(posedge clk_32f);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/phy_rx_deframer.md
Name: phy_rx_deframer

Overview:
- Receive-side stage directly downstream of the TX serializer. Consumes its 1-bit stream on clk_32f.
- Finds byte alignment by hunting for the 0xBC idle symbol and declares the link active after BC_LOCK consecutive aligned BC bytes.
- Once active, de-interleaves bytes round-robin back into four 8-bit lanes with per-lane valids, undoing the TX L1/L2 mux order (lane 0,1,2,3).
- Everything runs in one clock domain; a frame_done strobe marks each completed 4-lane set for slower-domain consumers.

Parameters:
- BC_SYMBOL, 8'hBC, idle/comma byte sent by TX when valid is low.
- BC_LOCK, 4, consecutive aligned BC bytes required to enter ACTIVE (range 1..15).

Ports:
- clk_32f  input  1  bit clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low; sampled on clk_32f rising edge.
- data_in  input  1  serial stream, MSB of each byte first.
- active  output  1  high while in ACTIVE state.
- byte_out  output  8  last assembled byte (ACTIVE only).
- byte_valid  output  1  one-cycle pulse per assembled byte in ACTIVE.
- data_out0..data_out3  output  8 each  lane registers.
- valid_out0..valid_out3  output  1 each  lane valid; high if the lane's last slot carried a non-BC byte.
- frame_done  output  1  one-cycle pulse when the lane 3 slot is written.

Behaviour:
- Reset (reset==0 at edge):
  - state=HUNT; shift register, bit_cnt, bc_cnt and lane_cnt = 0.
  - All outputs = 0.
  - Reset is honoured mid-byte and in any state; the partial byte is discarded.
- Shift: every cycle, sr <= {sr[6:0], data_in}. cand = {sr[6:0], data_in} is the byte ending with the current bit.
- HUNT:
  - Each cycle compare cand with BC_SYMBOL.
  - On match: bit_cnt <= 0, bc_cnt <= 1, go to SYNC. If BC_LOCK==1, go straight to ACTIVE instead.
  - No outputs change.
- SYNC:
  - bit_cnt counts 0..7 and wraps to 0. A byte boundary is the cycle with bit_cnt==7; evaluate cand there.
  - If cand==BC and bc_cnt+1==BC_LOCK: go to ACTIVE, lane_cnt <= 0.
  - Else if cand==BC: bc_cnt <= bc_cnt+1.
  - Else (non-BC): go to HUNT, bc_cnt <= 0. The current bit is not re-checked in the same cycle.
- ACTIVE:
  - active=1 from the first cycle after the locking boundary.
  - At each byte boundary, on the next edge:
    - byte_out <= cand; byte_valid <= 1 for exactly one cycle.
    - data_out[lane_cnt] <= cand.
    - valid_out[lane_cnt] <= (cand != BC_SYMBOL).
    - lane_cnt <= lane_cnt+1, 2-bit wrap 3->0.
    - frame_done <= 1 for one cycle when lane_cnt==3.
  - A BC byte consumes its lane slot: data_out is still written with 0xBC and valid_out goes low. Other lanes hold their values.
  - ACTIVE is sticky until reset. There is no loss-of-lock detection in this block.
- Latency: outputs update on the edge after the cycle in which the byte's last (LSB) bit is on data_in, i.e. 1 clk_32f after the last bit.
- Simultaneous events: reset low overrides all state and output updates in the same cycle. The locking boundary itself produces no byte_valid; the first data slot is the next byte.
- Width rules: bc_cnt is 4 bits and saturates at BC_LOCK; bit_cnt is 3 bits; lane_cnt is 2 bits.

Test Plan:
- Reset hold: drive reset=0 for 3 cycles with random data_in -> all outputs 0, active=0, no byte_valid pulses.
- Lock with offset: release reset, send 3 random bits then BC x4 -> active rises 1 cycle after the last bit of the 4th BC. Then send 0x11,0x22,0x33,0x44 -> data_out0..3 = 11,22,33,44, valid_out0..3 = 1, byte_valid pulses 4 times 8 cycles apart, frame_done pulses once, after 0x44.
- Broken lock: send BC,BC,BC,0x5A,BC x4 -> active stays 0 through 0x5A and rises only after the 4 following BCs.
- Idle slot: in ACTIVE send 0xA1,BC,0xA3,0xA4 -> data_out1 = 0xBC, valid_out1 = 0, other lanes valid with their values, frame_done pulses once.
- Lane wrap: send 8 data bytes 0x01..0x08 -> after the second frame data_out0..3 = 05,06,07,08, frame_done pulses twice.
- Reset mid-byte: assert reset at bit 4 of a data byte in ACTIVE -> next edge all outputs 0, state HUNT. Full BC x4 relock is required before active rises again.
